// File: rtl/strip_pkg.sv
// Shared types and constants for the strip-mining controller: FSM states,
// the default vector register length and the legal SEW/LMUL encodings.
package strip_pkg;

   localparam int VLEN_DEFAULT = 64;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ISSUE
   } state_t;

   localparam logic [6:0] LEGAL_SEW  [5] = '{7'd4, 7'd8, 7'd16, 7'd32, 7'd64};
   localparam logic [3:0] LEGAL_LMUL [5] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd16};

   function automatic logic sew_in_list(input logic [6:0] sew);
      logic hit;
      hit = 1'b0;
      foreach (LEGAL_SEW[i])
         if (LEGAL_SEW[i] == sew) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic lmul_in_list(input logic [3:0] lmul);
      logic hit;
      hit = 1'b0;
      foreach (LEGAL_LMUL[i])
         if (LEGAL_LMUL[i] == lmul) hit = 1'b1;
      return hit;
   endfunction

endpackage

// File: rtl/cfg_legal_chk.sv
// Combinational legality check of a (sew, lmul) pair against the supported
// encodings; an element wider than the vector register is never legal.
module cfg_legal_chk
   import strip_pkg::*;
#(
   parameter int VLEN = VLEN_DEFAULT
) (
   input  logic [6:0] sew,
   input  logic [3:0] lmul,
   output logic       valid_sew,
   output logic       valid_lmul
);

   assign valid_sew  = sew_in_list(sew) && ({25'd0, sew} <= 32'(VLEN));
   assign valid_lmul = lmul_in_list(lmul);

endmodule

// File: rtl/strip_mine_ctrl.sv
// Strip-mining controller: splits a job of cfg_avl elements into strips sized
// by the vl setup unit. Define STRIP_ABORT_EN to add the abort input.
module strip_mine_ctrl
   import strip_pkg::*;
#(
   parameter int VLEN = VLEN_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
`ifdef STRIP_ABORT_EN
   input  logic       abort,
`endif
   input  logic       start_valid,
   output logic       start_ready,
   input  logic [7:0] cfg_avl,
   input  logic [6:0] cfg_sew,
   input  logic [3:0] cfg_lmul,
   output logic [6:0] req_sew,
   output logic [3:0] req_lmul,
   output logic [7:0] req_avl,
   output logic       req_valid_sew,
   output logic       req_valid_lmul,
   input  logic       rsp_en,
   input  logic [7:0] rsp_vl,
   input  logic [7:0] rsp_new_avl,
   output logic       strip_valid,
   input  logic       strip_ready,
   output logic [7:0] strip_vl,
   output logic [7:0] strip_idx,
   output logic       strip_last,
   output logic       busy,
   output logic       done,
   output logic       err
);

   state_t     state, state_d;
   logic [6:0] sew_q, sew_d;
   logic [3:0] lmul_q, lmul_d;
   logic [7:0] remaining, remaining_d;
   logic [7:0] vl_d, idx_d;
   logic       last_d, done_d, err_d;
   logic       sew_ok, lmul_ok;
   logic       abort_hit;

   cfg_legal_chk #(.VLEN(VLEN)) u_chk (
      .sew        (sew_q),
      .lmul       (lmul_q),
      .valid_sew  (sew_ok),
      .valid_lmul (lmul_ok)
   );

`ifdef STRIP_ABORT_EN
   assign abort_hit = abort && (state != IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   assign start_ready    = (state == IDLE);
   assign busy           = (state != IDLE);
   assign strip_valid    = (state == ISSUE);
   assign req_sew        = (state == REQ) ? sew_q : 7'd0;
   assign req_lmul       = (state == REQ) ? lmul_q : 4'd0;
   assign req_avl        = (state == REQ) ? remaining : 8'd0;
   assign req_valid_sew  = (state == REQ) && sew_ok;
   assign req_valid_lmul = (state == REQ) && lmul_ok;

   always_comb begin
      state_d     = state;
      sew_d       = sew_q;
      lmul_d      = lmul_q;
      remaining_d = remaining;
      vl_d        = strip_vl;
      idx_d       = strip_idx;
      last_d      = strip_last;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state)
         IDLE: begin
            if (start_valid) begin
               sew_d       = cfg_sew;
               lmul_d      = cfg_lmul;
               remaining_d = cfg_avl;
               idx_d       = 8'd0;
               if (cfg_avl == 8'd0) done_d = 1'b1;
               else                 state_d = REQ;
            end
         end
         REQ: begin
            // A refused or empty grant means the job cannot make progress.
            if (!rsp_en || (rsp_vl == 8'd0)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               vl_d        = rsp_vl;
               remaining_d = rsp_new_avl;
               last_d      = (rsp_new_avl == 8'd0);
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (strip_ready) begin
               if (strip_last) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d   = strip_idx + 8'd1;
                  state_d = REQ;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort_hit) begin
         state_d = IDLE;
         done_d  = 1'b0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sew_q      <= 7'd0;
         lmul_q     <= 4'd0;
         remaining  <= 8'd0;
         strip_vl   <= 8'd0;
         strip_idx  <= 8'd0;
         strip_last <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_d;
         sew_q      <= sew_d;
         lmul_q     <= lmul_d;
         remaining  <= remaining_d;
         strip_vl   <= vl_d;
         strip_idx  <= idx_d;
         strip_last <= last_d;
         done       <= done_d;
         err        <= err_d;
      end
   end

endmodule

// File: tb/tb_strip_mine_ctrl.sv
// Scoreboard bench for strip_mine_ctrl with a behavioural vl setup unit
// (vlmax = (64/sew)*lmul); abort cases run when STRIP_ABORT_EN is defined.
module tb_strip_mine_ctrl;

   localparam int KIND_STRIP = 0;
   localparam int KIND_DONE  = 1;
   localparam int KIND_ERR   = 2;

   typedef struct {
      int         kind;
      logic [7:0] vl;
      logic [7:0] idx;
      logic       last;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start_valid;
   logic       start_ready;
   logic [7:0] cfg_avl;
   logic [6:0] cfg_sew;
   logic [3:0] cfg_lmul;
   logic [6:0] req_sew;
   logic [3:0] req_lmul;
   logic [7:0] req_avl;
   logic       req_valid_sew;
   logic       req_valid_lmul;
   logic       rsp_en;
   logic [7:0] rsp_vl;
   logic [7:0] rsp_new_avl;
   logic       strip_valid;
   logic       strip_ready;
   logic [7:0] strip_vl;
   logic [7:0] strip_idx;
   logic       strip_last;
   logic       busy;
   logic       done;
   logic       err;
`ifdef STRIP_ABORT_EN
   logic       abort;
`endif

   logic       zero_vl;
   int         vlmax;
   int         vl_grant;
   int         checks;
   int         errors;
   exp_t       exp_q[$];

   strip_mine_ctrl #(.VLEN(64)) dut (
      .clk            (clk),
      .rst            (rst),
`ifdef STRIP_ABORT_EN
      .abort          (abort),
`endif
      .start_valid    (start_valid),
      .start_ready    (start_ready),
      .cfg_avl        (cfg_avl),
      .cfg_sew        (cfg_sew),
      .cfg_lmul       (cfg_lmul),
      .req_sew        (req_sew),
      .req_lmul       (req_lmul),
      .req_avl        (req_avl),
      .req_valid_sew  (req_valid_sew),
      .req_valid_lmul (req_valid_lmul),
      .rsp_en         (rsp_en),
      .rsp_vl         (rsp_vl),
      .rsp_new_avl    (rsp_new_avl),
      .strip_valid    (strip_valid),
      .strip_ready    (strip_ready),
      .strip_vl       (strip_vl),
      .strip_idx      (strip_idx),
      .strip_last     (strip_last),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural vl setup unit; zero_vl forces a degenerate empty grant.
   always_comb begin
      rsp_en      = 1'b0;
      rsp_vl      = 8'd0;
      rsp_new_avl = 8'd0;
      vlmax       = 0;
      vl_grant    = 0;
      if (req_valid_sew && req_valid_lmul && (req_sew != 7'd0)) begin
         vlmax       = (64 / int'(req_sew)) * int'(req_lmul);
         vl_grant    = (int'(req_avl) < vlmax) ? int'(req_avl) : vlmax;
         rsp_en      = 1'b1;
         rsp_vl      = 8'(vl_grant);
         rsp_new_avl = 8'(int'(req_avl) - vl_grant);
         if (zero_vl) begin
            rsp_vl      = 8'd0;
            rsp_new_avl = req_avl;
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_strip(input logic [7:0] vl, input logic [7:0] idx, input logic last);
      exp_t e;
      e.kind = KIND_STRIP;
      e.vl   = vl;
      e.idx  = idx;
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic push_event(input int kind);
      exp_t e;
      e.kind = kind;
      e.vl   = 8'd0;
      e.idx  = 8'd0;
      e.last = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL unexpected_output: got kind %0d, expected nothing", kind);
      end else begin
         e = exp_q.pop_front();
         check_output("event_kind", kind, e.kind);
         if (kind == KIND_STRIP && e.kind == KIND_STRIP) begin
            check_output("strip_vl", strip_vl, e.vl);
            check_output("strip_idx", strip_idx, e.idx);
            check_output("strip_last", strip_last, e.last);
         end
      end
   endtask

   // Monitor: consumes strip handshakes and done/err pulses from the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (done || err) check_output("done_err_exclusive", done & err, 0);
         if (strip_valid && strip_ready) pop_check(KIND_STRIP);
         if (done) pop_check(KIND_DONE);
         if (err)  pop_check(KIND_ERR);
      end
   end

   // Presents one job for one cycle; returns in cycle T+1 after the accept.
   task automatic apply_stimulus(input logic [7:0] avl, input logic [6:0] sew,
                                 input logic [3:0] lmul);
      cfg_avl     = avl;
      cfg_sew     = sew;
      cfg_lmul    = lmul;
      start_valid = 1'b1;
      tick();
      start_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy && n < budget) begin
         tick();
         n++;
      end
      check_output({name, "_idle"}, busy, 0);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      start_valid = 1'b0;
      cfg_avl     = 8'd0;
      cfg_sew     = 7'd0;
      cfg_lmul    = 4'd0;
      strip_ready = 1'b0;
      zero_vl     = 1'b0;
`ifdef STRIP_ABORT_EN
      abort       = 1'b0;
`endif
      tick();
      tick();
      check_output("rst_start_ready", start_ready, 1);
      check_output("rst_busy", busy, 0);
      check_output("rst_strip_valid", strip_valid, 0);
      check_output("rst_done", done, 0);
      check_output("rst_err", err, 0);
      check_output("rst_strip_vl", strip_vl, 0);
      check_output("rst_req_valid_sew", req_valid_sew, 0);
      rst = 1'b0;
      tick();

      // AVL=20, SEW=8, LMUL=1: strips 8,8,4
      $display("[TB] three-strip job");
      push_strip(8'd8, 8'd0, 1'b0);
      push_strip(8'd8, 8'd1, 1'b0);
      push_strip(8'd4, 8'd2, 1'b1);
      push_event(KIND_DONE);
      strip_ready = 1'b1;
      apply_stimulus(8'd20, 7'd8, 4'd1);
      check_output("t1_busy", busy, 1);
      check_output("t1_start_ready", start_ready, 0);
      check_output("t1_req_avl", req_avl, 20);
      check_output("t1_req_valid_sew", req_valid_sew, 1);
      check_output("t1_strip_valid", strip_valid, 0);
      tick();
      check_output("t2_strip_valid", strip_valid, 1);
      wait_idle("three_strip", 20);
      check_output("three_strip_done", done, 1);
      tick();
      check_output("done_one_cycle", done, 0);

      // AVL=0: immediate done, no strip
      $display("[TB] empty job");
      push_event(KIND_DONE);
      apply_stimulus(8'd0, 7'd8, 4'd1);
      check_output("avl0_done", done, 1);
      check_output("avl0_busy", busy, 0);
      check_output("avl0_strip_valid", strip_valid, 0);
      check_output("avl0_start_ready", start_ready, 1);
      tick();
      check_output("avl0_done_drop", done, 0);

      // SEW=12: illegal width
      $display("[TB] illegal sew");
      push_event(KIND_ERR);
      strip_ready = 1'b0;
      apply_stimulus(8'd10, 7'd12, 4'd1);
      check_output("sew12_req_valid_sew", req_valid_sew, 0);
      check_output("sew12_req_valid_lmul", req_valid_lmul, 1);
      check_output("sew12_rsp_en", rsp_en, 0);
      tick();
      check_output("sew12_err", err, 1);
      check_output("sew12_busy", busy, 0);
      check_output("sew12_strip_valid", strip_valid, 0);
      tick();
      check_output("sew12_err_drop", err, 0);

      // LMUL=3: illegal grouping
      $display("[TB] illegal lmul");
      push_event(KIND_ERR);
      apply_stimulus(8'd10, 7'd8, 4'd3);
      check_output("lmul3_req_valid_lmul", req_valid_lmul, 0);
      check_output("lmul3_req_valid_sew", req_valid_sew, 1);
      tick();
      check_output("lmul3_err", err, 1);

      // Legal config but empty grant
      $display("[TB] zero vl grant");
      push_event(KIND_ERR);
      zero_vl = 1'b1;
      apply_stimulus(8'd10, 7'd8, 4'd1);
      tick();
      check_output("zero_vl_err", err, 1);
      check_output("zero_vl_strip_valid", strip_valid, 0);
      zero_vl = 1'b0;
      tick();

      // AVL=16, SEW=16, LMUL=2 with back-pressure; busy start_valid ignored
      $display("[TB] back-pressure");
      push_strip(8'd8, 8'd0, 1'b0);
      push_strip(8'd8, 8'd1, 1'b1);
      push_event(KIND_DONE);
      apply_stimulus(8'd16, 7'd16, 4'd2);
      tick();
      cfg_avl     = 8'd99;
      start_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check_output("bp_strip_valid", strip_valid, 1);
         check_output("bp_strip_vl", strip_vl, 8);
         check_output("bp_strip_idx", strip_idx, 0);
         check_output("bp_strip_last", strip_last, 0);
         tick();
      end
      start_valid = 1'b0;
      check_output("bp_strip_valid_4", strip_valid, 1);
      check_output("bp_strip_vl_4", strip_vl, 8);
      strip_ready = 1'b1;
      wait_idle("backpressure", 20);
      check_output("bp_done", done, 1);
      tick();

      // Reset during ISSUE of strip 1
      $display("[TB] reset mid-job");
      push_strip(8'd8, 8'd0, 1'b0);
      strip_ready = 1'b0;
      apply_stimulus(8'd20, 7'd8, 4'd1);
      tick();
      check_output("mid_strip0_valid", strip_valid, 1);
      strip_ready = 1'b1;
      tick();
      strip_ready = 1'b0;
      tick();
      check_output("mid_strip1_valid", strip_valid, 1);
      check_output("mid_strip1_idx", strip_idx, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_output("mid_rst_strip_valid", strip_valid, 0);
      check_output("mid_rst_start_ready", start_ready, 1);
      check_output("mid_rst_busy", busy, 0);
      check_output("mid_rst_done", done, 0);
      check_output("mid_rst_idx", strip_idx, 0);
      tick();

      // Fresh job after reset: AVL=5, SEW=32 -> strips 2,2,1
      $display("[TB] job after reset");
      push_strip(8'd2, 8'd0, 1'b0);
      push_strip(8'd2, 8'd1, 1'b0);
      push_strip(8'd1, 8'd2, 1'b1);
      push_event(KIND_DONE);
      strip_ready = 1'b1;
      apply_stimulus(8'd5, 7'd32, 4'd1);
      wait_idle("after_reset", 20);
      tick();

`ifdef STRIP_ABORT_EN
      // Abort during REQ of strip 2
      $display("[TB] abort");
      push_strip(8'd8, 8'd0, 1'b0);
      push_strip(8'd8, 8'd1, 1'b0);
      apply_stimulus(8'd20, 7'd8, 4'd1);
      tick();
      tick();
      tick();
      tick();
      check_output("abort_req_avl", req_avl, 4);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_output("abort_busy", busy, 0);
      check_output("abort_strip_valid", strip_valid, 0);
      check_output("abort_done", done, 0);
      check_output("abort_err", err, 0);
      check_output("abort_start_ready", start_ready, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_output("abort_idle_ignored", start_ready, 1);
`endif

      for (int k = 0; k < 4; k++) tick();
      check_output("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
